dram_ctrl: RTL



---
 rtl/dram_ctrl.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/dram_ctrl.sv
// dram_ctrl: command-issuing front end for the dram bank model.
// Splits client requests into bank/row/col, sequences PRE/ACT/RD/WR,
// tracks open rows per bank, captures read data and schedules REFRESH.
// Optional feature macro: DRAM_CTRL_OPEN_PAGE_EN (open-page policy).
// Without it the controller runs close-page: every access is ACT -> RW -> CLOSE.
// The state register always names the command currently on the pins;
// the next command is decoded from the next state and registered with it.
module dram_ctrl #(
  parameter int  NUMBER_OF_COLUMNS = 8,
  parameter int  NUMBER_OF_ROWS    = 128,
  parameter int  NUMBER_OF_BANKS   = 8,
  parameter int  DRAM_DATA_WIDTH   = 2,
  parameter int  REFRESH_INTERVAL  = 1000,
  localparam int COLUMN_WIDTH    = $clog2(NUMBER_OF_COLUMNS / DRAM_DATA_WIDTH),
  localparam int ROW_WIDTH       = $clog2(NUMBER_OF_ROWS),
  localparam int BANK_ID_WIDTH   = $clog2(NUMBER_OF_BANKS),
  localparam int U_ADDR_WIDTH    = BANK_ID_WIDTH + ROW_WIDTH + COLUMN_WIDTH,
  localparam int DRAM_ADDR_WIDTH = (ROW_WIDTH > COLUMN_WIDTH) ? ROW_WIDTH : COLUMN_WIDTH
) (
  input  logic                       dram_clk,
  input  logic                       dram_rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [U_ADDR_WIDTH-1:0]    req_addr,
  input  logic [DRAM_DATA_WIDTH-1:0] req_wr_data,
  output logic                       rsp_valid,
  output logic [DRAM_DATA_WIDTH-1:0] rsp_rd_data,
  output logic                       refresh_busy,
  output logic                       dram_cs_n,
  output logic                       dram_ras_n,
  output logic                       dram_cas_n,
  output logic                       dram_we_n,
  output logic                       dram_clk_en,
  output logic [DRAM_ADDR_WIDTH-1:0] dram_addr,
  output logic [BANK_ID_WIDTH-1:0]   dram_bank_id,
  output logic [DRAM_DATA_WIDTH-1:0] dram_wr_data,
  input  logic [DRAM_DATA_WIDTH-1:0] dram_rd_data,
  input  logic                       dram_refresh_done
);

  localparam int CNT_W = $clog2(REFRESH_INTERVAL);

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_DES = 4'b1111;
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_REF = 4'b0001;

  typedef enum logic [2:0] {
    IDLE, PRE, ACT, RW, CLOSE, REF_PRE, REF_CMD, REF_WAIT
  } state_e;

  typedef struct packed {
    logic                       we;
    logic [BANK_ID_WIDTH-1:0]   bank;
    logic [ROW_WIDTH-1:0]       row;
    logic [COLUMN_WIDTH-1:0]    col;
    logic [DRAM_DATA_WIDTH-1:0] wdata;
  } req_t;

  state_e state_q, state_d;
  req_t   req_q, req_d, in_req;
  logic [NUMBER_OF_BANKS-1:0]                open_q, open_d;
  logic [NUMBER_OF_BANKS-1:0][ROW_WIDTH-1:0] open_row_q, open_row_d;
  logic [NUMBER_OF_BANKS-1:0]                pre_mask_q, pre_mask_d, ref_src;
  logic [BANK_ID_WIDTH-1:0]                  ref_bank;
  logic [3:0]                 cmd_q, cmd_d;
  logic [DRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BANK_ID_WIDTH-1:0]   bank_q, bank_d;
  logic [DRAM_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                       clk_en_q, started_q;
  logic [CNT_W-1:0]           ref_cnt_q;
  logic                       ref_pending_q;
  logic [1:0]                 vld_pipe_q;
  logic [DRAM_DATA_WIDTH-1:0] rsp_data_q;
  logic                       accept;

  // Lowest set bank in a mask; refresh precharges walk banks in ascending order.
  function automatic logic [BANK_ID_WIDTH-1:0] lowest(input logic [NUMBER_OF_BANKS-1:0] m);
    lowest = '0;
    for (int i = NUMBER_OF_BANKS - 1; i >= 0; i--)
      if (m[i]) lowest = BANK_ID_WIDTH'(i);
  endfunction

  assign in_req = '{we:    req_we,
                    bank:  req_addr[U_ADDR_WIDTH-1 -: BANK_ID_WIDTH],
                    row:   req_addr[COLUMN_WIDTH +: ROW_WIDTH],
                    col:   req_addr[COLUMN_WIDTH-1:0],
                    wdata: req_wr_data};

  // started_q keeps req_ready low until the first edge after reset release.
  assign req_ready    = started_q && (state_q == IDLE) && !ref_pending_q;
  assign accept       = req_valid && req_ready;
  assign refresh_busy = (state_q == REF_PRE) || (state_q == REF_CMD) || (state_q == REF_WAIT);

  // From IDLE the refresh walk starts on all open banks; afterwards on what is left.
  assign ref_src  = (state_q == IDLE) ? open_q : pre_mask_q;
  assign ref_bank = lowest(ref_src);

  // Next-state, request latch and per-bank open-row bookkeeping.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    open_d     = open_q;
    open_row_d = open_row_q;
    pre_mask_d = pre_mask_q;
    case (state_q)
      IDLE: begin
        if (ref_pending_q) begin
          state_d = (|open_q) ? REF_PRE : REF_CMD;
        end else if (accept) begin
          req_d = in_req;
          if (!open_q[in_req.bank])                         state_d = ACT;
          else if (open_row_q[in_req.bank] == in_req.row)  state_d = RW;
          else                                             state_d = PRE;
        end
      end
      PRE: state_d = ACT;
      ACT: begin
        state_d                 = RW;
        open_d[req_q.bank]      = 1'b1;
        open_row_d[req_q.bank]  = req_q.row;
      end
`ifdef DRAM_CTRL_OPEN_PAGE_EN
      RW: state_d = IDLE;
`else
      RW: state_d = CLOSE;
`endif
      CLOSE: begin
        state_d            = IDLE;
        open_d[req_q.bank] = 1'b0;
      end
      REF_PRE:  state_d = (|pre_mask_q) ? REF_PRE : REF_CMD;
      REF_CMD:  state_d = REF_WAIT;
      REF_WAIT: begin
        if (dram_refresh_done) begin
          state_d = IDLE;
          open_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == REF_PRE)
      pre_mask_d = ref_src & ~(NUMBER_OF_BANKS'(1) << ref_bank);
  end

  // Command/address for the state being entered, so pins and state stay aligned.
  always_comb begin
    cmd_d   = CMD_NOP;
    addr_d  = addr_q;
    bank_d  = bank_q;
    wdata_d = wdata_q;
    case (state_d)
      PRE: begin
        cmd_d  = CMD_PRE;
        bank_d = req_d.bank;
        addr_d = DRAM_ADDR_WIDTH'(open_row_q[req_d.bank]);
      end
      ACT: begin
        cmd_d  = CMD_ACT;
        bank_d = req_d.bank;
        addr_d = DRAM_ADDR_WIDTH'(req_d.row);
      end
      RW: begin
        cmd_d  = req_d.we ? CMD_WR : CMD_RD;
        bank_d = req_d.bank;
        addr_d = DRAM_ADDR_WIDTH'(req_d.col);
        if (req_d.we) wdata_d = req_d.wdata;
      end
      CLOSE: begin
        cmd_d  = CMD_PRE;
        bank_d = req_d.bank;
        addr_d = DRAM_ADDR_WIDTH'(req_d.row);
      end
      REF_PRE: begin
        cmd_d  = CMD_PRE;
        bank_d = ref_bank;
        addr_d = DRAM_ADDR_WIDTH'(open_row_q[ref_bank]);
      end
      REF_CMD: cmd_d = CMD_REF;
      default: ;
    endcase
  end

  // FSM, bank table and registered DRAM-side outputs.
  always_ff @(posedge dram_clk or negedge dram_rst_n) begin
    if (!dram_rst_n) begin
      state_q    <= IDLE;
      req_q      <= '0;
      open_q     <= '0;
      open_row_q <= '0;
      pre_mask_q <= '0;
      cmd_q      <= CMD_DES;
      addr_q     <= '0;
      bank_q     <= '0;
      wdata_q    <= '0;
      clk_en_q   <= 1'b0;
      started_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      open_q     <= open_d;
      open_row_q <= open_row_d;
      pre_mask_q <= pre_mask_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      bank_q     <= bank_d;
      wdata_q    <= wdata_d;
      clk_en_q   <= 1'b1;
      started_q  <= 1'b1;
    end
  end

  // Free-running refresh timer; a wrap while already pending is absorbed.
  always_ff @(posedge dram_clk or negedge dram_rst_n) begin
    if (!dram_rst_n) begin
      ref_cnt_q     <= '0;
      ref_pending_q <= 1'b0;
    end else if (ref_cnt_q == CNT_W'(REFRESH_INTERVAL - 1)) begin
      ref_cnt_q     <= '0;
      ref_pending_q <= 1'b1;
    end else begin
      ref_cnt_q <= ref_cnt_q + 1'b1;
      if (state_q == REF_CMD) ref_pending_q <= 1'b0;
    end
  end

  // Read return: data is valid on the pins one cycle after READ, response follows.
  always_ff @(posedge dram_clk or negedge dram_rst_n) begin
    if (!dram_rst_n) begin
      vld_pipe_q <= '0;
      rsp_data_q <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[0], (state_q == RW) && !req_q.we};
      if (vld_pipe_q[0]) rsp_data_q <= dram_rd_data;
    end
  end

  assign {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} = cmd_q;
  assign dram_clk_en  = clk_en_q;
  assign dram_addr    = addr_q;
  assign dram_bank_id = bank_q;
  assign dram_wr_data = wdata_q;
  assign rsp_valid    = vld_pipe_q[1];
  assign rsp_rd_data  = rsp_data_q;

endmodule
